// File: rtl/bmr_tdee_pio_pkg.sv
// Shared definitions for the debounced PIO input block: register map and
// edge-capture mode selection.
package bmr_tdee_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/bmr_tdee_pio_debounce.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by a debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module bmr_tdee_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_sync,
    output logic o_deb
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_deb = o_sync;
        end else begin : g_count
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_deb;

            // Any cycle of agreement restarts the stability window.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (o_sync != r_deb) begin
                    if (r_cnt == CNT_LAST) begin
                        r_deb <= o_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_deb = r_deb;
        end
    endgenerate

endmodule

// File: rtl/bmr_tdee_qsys_pio_in_irq.sv
// Avalon-MM PIO input with per-bit synchronise/debounce, edge capture and a
// masked level interrupt driven only from registers.
module bmr_tdee_qsys_pio_in_irq
    import bmr_tdee_pio_pkg::*;
#(
    parameter int         WIDTH           = 2,
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter edge_type_e EDGE_TYPE       = RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_next;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        bmr_tdee_pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .i_in   (in_port[g]),
            .o_sync (w_sync[g]),
            .o_deb  (w_deb[g])
        );
    end

    if (WIDTH < 32) begin : g_unused
        logic w_unused_wd;
        assign w_unused_wd = ^writedata[31:WIDTH];
    end

    // Both registers reset to 0, so a post-reset low level never looks like an edge.
    always_comb begin
        w_det = '0;
        case (EDGE_TYPE)
            RISING:  w_det = w_deb & ~r_deb_d;
            FALLING: w_det = ~w_deb & r_deb_d;
            default: w_det = w_deb ^ r_deb_d;
        endcase
    end

    assign w_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA: w_rd_next[WIDTH-1:0] = w_deb;
            ADDR_RAW:  w_rd_next[WIDTH-1:0] = w_sync;
            ADDR_MASK: w_rd_next[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd_next[WIDTH-1:0] = r_edge;
        endcase
    end

    // A capture in the same cycle as a clear is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d    <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
        end else begin
            r_deb_d    <= w_deb;
            r_edge     <= (r_edge & ~w_clr) | w_det;
            r_readdata <= w_rd_next;
            if (write && address == ADDR_MASK) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_bmr_tdee_qsys_pio_in_irq.sv
// Bench for the debounced PIO input block (WIDTH=2, 2 sync stages, 4-cycle
// debounce, rising-edge capture) against a cycle-level behavioural model.
module tb_bmr_tdee_qsys_pio_in_irq;
    import bmr_tdee_pio_pkg::*;

    localparam int DC = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    bmr_tdee_qsys_pio_in_irq #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (RISING)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .in_port  (in_port),
        .readdata (readdata),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inputs seen two edges late, a bit's level accepted after
    // DC consecutive disagreeing samples, rises latched one edge later.
    logic [1:0]  m_pipe[$];
    int          m_run[2];
    logic [1:0]  m_deb, m_rose, m_edge, m_mask;
    logic [31:0] m_rd;
    logic        m_irq;

    task automatic model_reset();
        m_pipe = '{2'b00, 2'b00};
        m_run[0] = 0;
        m_run[1] = 0;
        m_deb = '0;
        m_rose = '0;
        m_edge = '0;
        m_mask = '0;
        m_rd = '0;
        m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0]  m_sync, deb_n, rose_n, edge_n, mask_n;
        logic [31:0] rd_n;
        m_sync = m_pipe[0];
        case (address)
            2'd0:    rd_n = {30'd0, m_deb};
            2'd1:    rd_n = {30'd0, m_sync};
            2'd2:    rd_n = {30'd0, m_mask};
            default: rd_n = {30'd0, m_edge};
        endcase
        edge_n = m_edge;
        if (write && address == 2'd3) edge_n = edge_n & ~writedata[1:0];
        edge_n = edge_n | m_rose;
        mask_n = (write && address == 2'd2) ? writedata[1:0] : m_mask;
        deb_n  = m_deb;
        rose_n = '0;
        for (int i = 0; i < 2; i++) begin
            if (m_sync[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    deb_n[i]  = m_sync[i];
                    rose_n[i] = m_sync[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pipe.push_back(in_port);
        void'(m_pipe.pop_front());
        m_deb  = deb_n;
        m_rose = rose_n;
        m_edge = edge_n;
        m_mask = mask_n;
        m_rd   = rd_n;
        m_irq  = |(edge_n & mask_n);
    endtask

    task automatic tick();
        if (reset_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        write     = 1'b0;
        address   = 2'd0;
        writedata = '0;
        in_port   = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_port   = 2'b11;
        write     = 1'b1;
        writedata = 32'hFFFF_FFFF;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            @(posedge clk);
            #1;
            n_checks++;
            if (readdata !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_readdata addr%0d: got %h expected 00000000", a, readdata);
            end
            n_checks++;
            if (irq !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_irq: got %b expected 0", irq);
            end
        end
        write   = 1'b0;
        in_port = 2'b00;
        reset_n = 1'b1;
        address = ADDR_MASK;
        tick();
        tick();
        n_checks++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            n_errors++;
            $display("FAIL reset_mask: got %h expected 00000000", readdata);
        end
    endtask

    task automatic test_latency();
        logic [31:0] exp_c;
        do_reset();
        address = ADDR_RAW;
        repeat (3) tick();
        in_port = 2'b01;
        for (int n = 1; n <= 7; n++) begin
            if (n == 4) address = ADDR_DATA;
            tick();
            n_checks++;
            if (readdata !== m_rd) begin
                n_errors++;
                $display("FAIL latency_model edge%0d: got %h expected %h", n, readdata, m_rd);
            end
            if (n == 2 || n == 3 || n == 6 || n == 7) begin
                exp_c = (n == 3 || n == 7) ? 32'h1 : 32'h0;
                n_checks++;
                if (readdata !== exp_c) begin
                    n_errors++;
                    $display("FAIL latency_fixed edge%0d: got %h expected %h", n, readdata, exp_c);
                end
            end
        end
        address = ADDR_EDGE;
        tick();
        n_checks++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_errors++;
            $display("FAIL latency_capture: got %h expected 00000001", readdata);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        address = ADDR_DATA;
        repeat (3) tick();
        for (int c = 0; c < 48; c++) begin
            if (c < 40 && c % 2 == 0) in_port[0] = ~in_port[0];
            tick();
            n_checks++;
            if (readdata !== 32'h0 || readdata !== m_rd) begin
                n_errors++;
                $display("FAIL glitch cyc%0d addr%0d: got %h expected 00000000", c, address, readdata);
            end
            address = (c % 2 == 0) ? ADDR_EDGE : ADDR_DATA;
        end
    endtask

    task automatic test_irq();
        do_reset();
        address   = ADDR_MASK;
        write     = 1'b1;
        writedata = 32'h3;
        tick();
        write   = 1'b0;
        in_port = 2'b10;
        address = ADDR_EDGE;
        for (int n = 1; n <= 8; n++) begin
            tick();
            n_checks++;
            if (irq !== m_irq) begin
                n_errors++;
                $display("FAIL irq_model edge%0d: got %b expected %b", n, irq, m_irq);
            end
        end
        n_checks++;
        if (readdata !== 32'h2 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_set: got rd=%h irq=%b expected rd=00000002 irq=1", readdata, irq);
        end
        write     = 1'b1;
        writedata = 32'h2;
        tick();
        write = 1'b0;
        n_checks++;
        if (irq !== 1'b0 || irq !== m_irq) begin
            n_errors++;
            $display("FAIL irq_clear: got %b expected 0", irq);
        end
        tick();
        n_checks++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            n_errors++;
            $display("FAIL irq_edge_after_clear: got %h expected 00000000", readdata);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        in_port = 2'b01;
        address = ADDR_EDGE;
        repeat (6) tick();
        write     = 1'b1;
        writedata = 32'h1;
        tick();
        write = 1'b0;
        tick();
        n_checks++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_errors++;
            $display("FAIL same_cycle_set_wins: got %h expected 00000001", readdata);
        end
    endtask

    task automatic test_mask();
        do_reset();
        in_port = 2'b11;
        address = ADDR_EDGE;
        repeat (8) tick();
        n_checks++;
        if (readdata !== 32'h3 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_zero: got rd=%h irq=%b expected rd=00000003 irq=0", readdata, irq);
        end
        address   = ADDR_MASK;
        write     = 1'b1;
        writedata = 32'h1;
        tick();
        write = 1'b0;
        n_checks++;
        if (irq !== 1'b1 || irq !== m_irq) begin
            n_errors++;
            $display("FAIL mask_enable_irq: got %b expected 1", irq);
        end
        tick();
        n_checks++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_errors++;
            $display("FAIL mask_readback: got %h expected 00000001", readdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_port = 2'b01;
        address = ADDR_DATA;
        repeat (4) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got rd=%h irq=%b expected rd=00000000 irq=0", readdata, irq);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            @(posedge clk);
            #1;
            n_checks++;
            if (readdata !== 32'h0 || irq !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid_hold addr%0d: got rd=%h irq=%b expected 0", a, readdata, irq);
            end
        end
        address = ADDR_DATA;
        reset_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            n_checks++;
            if (readdata !== m_rd) begin
                n_errors++;
                $display("FAIL reset_mid_model edge%0d: got %h expected %h", n, readdata, m_rd);
            end
            if (n == 6 || n == 7) begin
                n_checks++;
                if (readdata !== ((n == 7) ? 32'h1 : 32'h0)) begin
                    n_errors++;
                    $display("FAIL reset_mid_redebounce edge%0d: got %h expected %0d", n, readdata, (n == 7));
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                in_port = 2'($urandom_range(0, 3));
                hold    = $urandom_range(1, 8);
            end
            hold--;
            address   = 2'($urandom_range(0, 3));
            write     = ($urandom_range(0, 5) == 0);
            writedata = $urandom;
            tick();
            n_checks++;
            if (readdata !== m_rd) begin
                n_errors++;
                $display("FAIL random_readdata cyc%0d: got %h expected %h", c, readdata, m_rd);
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_errors++;
                $display("FAIL random_irq cyc%0d: got %b expected %b", c, irq, m_irq);
            end
        end
        write = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        write     = 1'b0;
        writedata = '0;
        in_port   = 2'b00;
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_irq();
        test_same_cycle();
        test_mask();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
